// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one synchronous-read, word-addressed unified memory between the
//   instruction-fetch port and the load/store port of the multi-cycle MIPS core.
//   MIPS virtual byte addresses are translated to memory word indices: text
//   (IMEM_BASE) maps to words 0..I_WORDS-1, data (DMEM_BASE) maps to words
//   I_WORDS..I_WORDS+D_WORDS-1. Every access runs IDLE -> ISSUE -> RESP.
//
//   Data wins arbitration unless fetch has been passed over STARVE_LIMIT
//   times in a row while waiting, in which case fetch wins.
//
//   Optional feature macro: ARB_RANGE_CHECK_EN
//     defined   : misaligned or out-of-region requests are acked with err=1
//                 one cycle after grant, with no memory access.
//     undefined : no checking; offsets wrap into the memory, err tied 0.
//
// Ports
//   clk_in, reset_n        clock (rising edge), async active-low reset
//   i_req/i_addr           fetch request, byte address (held until i_ack)
//   i_ack/i_rdata/i_err    fetch completion pulse, data, error
//   d_req/d_we/d_addr/
//   d_wdata                load/store request (held until d_ack)
//   d_ack/d_rdata/d_err    data completion pulse, load data, error
//   mem_en/mem_we/
//   mem_addr/mem_wdata     registered memory strobe, write enable, index, data
//   mem_rdata              memory read data, valid the cycle after sampling
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned MEM_AW       = 12,
   parameter int unsigned I_WORDS      = 2048,
   parameter int unsigned D_WORDS      = 2048,
   parameter logic [31:0] IMEM_BASE    = 32'h0040_0000,
   parameter logic [31:0] DMEM_BASE    = 32'h1001_0000,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_ack,
   output logic [31:0]       i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   if (I_WORDS + D_WORDS > (1 << MEM_AW)) begin : g_bad_cfg
      $error("mem_arbiter: I_WORDS + D_WORDS exceeds the memory size");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state_q, state_d;
   logic              gnt_dat_q, gnt_dat_d;  // access in flight belongs to the data port
   logic              st_q, st_d;            // access in flight is a store
   logic              err_q, err_d;          // access in flight was rejected
   logic [CW-1:0]     starve_q, starve_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic [MEM_AW-1:0] i_idx, d_idx;
   logic              i_bad, d_bad;
   logic              pick_data;

   // 32-bit wrapping offset from the window base, then word index truncated
   // to the memory width; data words sit above the instruction region.
   assign i_idx = MEM_AW'((i_addr - IMEM_BASE) >> 2);
   assign d_idx = MEM_AW'(32'(I_WORDS) + ((d_addr - DMEM_BASE) >> 2));

`ifdef ARB_RANGE_CHECK_EN
   assign i_bad = (i_addr[1:0] != 2'b00) || (((i_addr - IMEM_BASE) >> 2) >= 32'(I_WORDS));
   assign d_bad = (d_addr[1:0] != 2'b00) || (((d_addr - DMEM_BASE) >> 2) >= 32'(D_WORDS));
`else
   assign i_bad = 1'b0;
   assign d_bad = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_dat_d   = gnt_dat_q;
      st_d        = st_q;
      err_d       = err_q;
      starve_d    = starve_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      pick_data   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               // Fetch only wins when data has starved it for the full limit.
               pick_data = d_req && !(i_req && (starve_q == STARVE_MAX));
               gnt_dat_d = pick_data;
               st_d      = pick_data && d_we;
               err_d     = pick_data ? d_bad : i_bad;

               if (pick_data && i_req)
                  starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
               else
                  starve_d = '0;

               if (err_d) begin
                  // Rejected access skips the memory entirely.
                  state_d = RESP;
               end else begin
                  state_d     = ISSUE;
                  mem_en_d    = 1'b1;
                  mem_we_d    = st_d;
                  mem_addr_d  = pick_data ? d_idx : i_idx;
                  mem_wdata_d = st_d ? d_wdata : '0;
               end
            end
         end
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         gnt_dat_q   <= 1'b0;
         st_q        <= 1'b0;
         err_q       <= 1'b0;
         starve_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_dat_q   <= gnt_dat_d;
         st_q        <= st_d;
         err_q       <= err_d;
         starve_q    <= starve_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Response is combinational off RESP; read data passes straight through
   // from the memory, which presents it in exactly this cycle.
   assign i_ack   = (state_q == RESP) && !gnt_dat_q;
   assign d_ack   = (state_q == RESP) &&  gnt_dat_q;
   assign i_err   = i_ack && err_q;
   assign d_err   = d_ack && err_q;
   assign i_rdata = (i_ack && !err_q) ? mem_rdata : 32'h0;
   assign d_rdata = (d_ack && !err_q && !st_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench. The driver process issues fetch/load/store requests and
//   a reference model predicts, per grant, the memory transaction and the
//   acknowledgement (cycle, port, data, error). A monitor process compares
//   the DUT's memory strobes and acks against those predictions.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int          MEM_AW  = 12;
   localparam int          I_WORDS = 2048;
   localparam int          D_WORDS = 2048;
   localparam int          LIMIT   = 4;
   localparam int          NWORDS  = 1 << MEM_AW;
   localparam logic [31:0] IB      = 32'h0040_0000;
   localparam logic [31:0] DB      = 32'h1001_0000;

   logic              clk_in  = 1'b0;
   logic              reset_n = 1'b0;
   logic              i_req   = 1'b0;
   logic [31:0]       i_addr  = '0;
   logic              i_ack;
   logic [31:0]       i_rdata;
   logic              i_err;
   logic              d_req   = 1'b0;
   logic              d_we    = 1'b0;
   logic [31:0]       d_addr  = '0;
   logic [31:0]       d_wdata = '0;
   logic              d_ack;
   logic [31:0]       d_rdata;
   logic              d_err;
   logic              mem_en;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;

   mem_arbiter #(
      .MEM_AW(MEM_AW), .I_WORDS(I_WORDS), .D_WORDS(D_WORDS),
      .IMEM_BASE(IB), .DMEM_BASE(DB), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(int k);
      if (k == 2) return 32'hDEAD_BEEF;
      return (32'(k) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   // Memory macro: synchronous read, data available the cycle after sampling.
   logic [31:0] mem [0:NWORDS-1];
   bit          mem_init = 1'b0;
   always @(posedge clk_in) begin
      if (!mem_init) begin
         for (int k = 0; k < NWORDS; k++) mem[k] <= init_word(k);
         mem_init <= 1'b1;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         if (mem_we) mem[mem_addr] <= mem_wdata;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { bit is_d; logic [31:0] rdata; bit err; int at; } ack_exp_t;
   typedef struct { bit we; logic [MEM_AW-1:0] addr; logic [31:0] wdata; int at; } mem_exp_t;

   ack_exp_t ack_q[$];
   mem_exp_t mem_q[$];
   bit       grant_log[$];
   int       n_checks = 0;
   int       n_err    = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:NWORDS-1];
   int          free_at = 0;  // first cycle the shared port can take a new grant
   int          starve  = 0;  // consecutive data grants while fetch waited
   int          i_mode  = 0;  // 0 off, 1 random, 2 always re-request
   int          d_mode  = 0;

   function automatic bit range_bad(logic [31:0] a, logic [31:0] base, int words);
`ifdef ARB_RANGE_CHECK_EN
      return (a[1:0] != 2'b00) || (((a - base) >> 2) >= 32'(words));
`else
      return 1'b0;
`endif
   endfunction

   task automatic model();
      bit          pick_d, bad, st;
      logic [31:0] a, word;
      int          idx;
      ack_exp_t    ae;
      mem_exp_t    me;
      if (!reset_n || cyc < free_at || !(i_req || d_req)) return;
      pick_d = d_req && !(i_req && starve == LIMIT);
      if (pick_d && i_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else                 starve = 0;
      st = pick_d && d_we;
      if (pick_d) begin
         a    = d_addr;
         bad  = range_bad(a, DB, D_WORDS);
         word = 32'(I_WORDS) + ((a - DB) >> 2);
      end else begin
         a    = i_addr;
         bad  = range_bad(a, IB, I_WORDS);
         word = (a - IB) >> 2;
      end
      idx = int'(word % NWORDS);
      ae.is_d = pick_d;
      if (bad) begin
         ae.rdata = '0; ae.err = 1'b1; ae.at = cyc + 1;
         free_at  = cyc + 2;
      end else begin
         me.we = st; me.addr = MEM_AW'(idx); me.wdata = st ? d_wdata : '0; me.at = cyc + 1;
         mem_q.push_back(me);
         ae.rdata = st ? 32'h0 : ref_mem[idx];
         if (st) ref_mem[idx] = d_wdata;
         ae.err = 1'b0; ae.at = cyc + 2;
         free_at = cyc + 3;
      end
      ack_q.push_back(ae);
   endtask

   // ---------------- requesters ----------------
   function automatic logic [31:0] gen_iaddr();
      if ($urandom_range(0, 7) == 0) return IB + $urandom_range(0, 20000) - 32'd64;
      return IB + 32'($urandom_range(0, I_WORDS - 1)) * 4;
   endfunction

   function automatic logic [31:0] gen_daddr();
      if ($urandom_range(0, 7) == 0) return DB + $urandom_range(0, 20000) - 32'd64;
      return DB + 32'($urandom_range(0, 31)) * 4;
   endfunction

   task automatic drop_acked();
      if (i_req && i_ack) i_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
   endtask

   task automatic step();
      @(negedge clk_in);
      drop_acked();
      if (reset_n && !i_req && (i_mode == 2 || (i_mode == 1 && $urandom_range(0, 2) == 0))) begin
         i_req = 1'b1; i_addr = gen_iaddr();
      end
      if (reset_n && !d_req && (d_mode == 2 || (d_mode == 1 && $urandom_range(0, 2) == 0))) begin
         d_req = 1'b1; d_addr = gen_daddr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      model();
   endtask

   task automatic drain();
      int n = 0;
      i_mode = 0; d_mode = 0;
      while ((i_req || d_req || ack_q.size() != 0 || cyc < free_at) && n < 40) begin
         step(); n++;
      end
      check("drain_ack_q_empty", ack_q.size(), 0);
      check("drain_mem_q_empty", mem_q.size(), 0);
   endtask

   task automatic check_idle_outputs(string tag);
      check({tag, "_i_ack"}, i_ack, 0);     check({tag, "_d_ack"}, d_ack, 0);
      check({tag, "_i_rdata"}, i_rdata, 0); check({tag, "_d_rdata"}, d_rdata, 0);
      check({tag, "_i_err"}, i_err, 0);     check({tag, "_d_err"}, d_err, 0);
      check({tag, "_mem_en"}, mem_en, 0);   check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      ack_exp_t ae;
      mem_exp_t me;
      forever begin
         @(negedge clk_in);
         if (reset_n) begin
            while (mem_q.size() != 0 && mem_q[0].at < cyc) begin
               me = mem_q.pop_front();
               check("mem_en_missing", 0, 1);
            end
            while (ack_q.size() != 0 && ack_q[0].at < cyc) begin
               ae = ack_q.pop_front();
               check("ack_missing", 0, 1);
            end
            if (mem_en) begin
               if (mem_q.size() == 0) check("mem_en_unexpected", 1, 0);
               else begin
                  me = mem_q.pop_front();
                  check("mem_cycle", cyc, me.at);
                  check("mem_we", mem_we, me.we);
                  check("mem_addr", 32'(mem_addr), 32'(me.addr));
                  if (me.we) check("mem_wdata", mem_wdata, me.wdata);
               end
            end
            if (i_ack || d_ack) begin
               check("ack_exclusive", i_ack && d_ack, 0);
               grant_log.push_back(d_ack);
               if (ack_q.size() == 0) check("ack_unexpected", 1, 0);
               else begin
                  ae = ack_q.pop_front();
                  check("ack_cycle", cyc, ae.at);
                  check("ack_port_is_data", d_ack, ae.is_d);
                  if (d_ack) begin
                     check("d_rdata", d_rdata, ae.rdata); check("d_err", d_err, ae.err);
                  end else begin
                     check("i_rdata", i_rdata, ae.rdata); check("i_err", i_err, ae.err);
                  end
               end
            end
            if (!i_ack) check("i_rdata_zero_when_idle", i_rdata, 0);
            if (!d_ack) check("d_rdata_zero_when_idle", d_rdata, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit exp_order [6] = '{1, 1, 1, 1, 0, 1};
      for (int k = 0; k < NWORDS; k++) ref_mem[k] = init_word(k);

      repeat (3) @(negedge clk_in);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      free_at = cyc;

      // Directed fetch: word 2 holds DEADBEEF.
      @(negedge clk_in);
      i_req = 1'b1; i_addr = 32'h0040_0008;
      model();
      drain();

      // Directed store to data word 1 -> memory word 2049.
      @(negedge clk_in);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'h1234_5678;
      model();
      drain();

      // Continuous contention: expect D,D,D,D,I,D.
      grant_log.delete();
      @(negedge clk_in);
      i_req = 1'b1; i_addr = gen_iaddr();
      d_req = 1'b1; d_we = 1'b0; d_addr = gen_daddr(); d_wdata = $urandom;
      model();
      i_mode = 2; d_mode = 2;
      repeat (20) step();
      drain();
      check("contention_grants", grant_log.size() >= 6, 1);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         check($sformatf("grant_order_%0d_is_data", k), grant_log[k], exp_order[k]);

`ifdef ARB_RANGE_CHECK_EN
      @(negedge clk_in);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0002;
      model();
      drain();
      @(negedge clk_in);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_2000; d_wdata = $urandom;
      model();
      drain();
`endif

      // Randomized traffic.
      i_mode = 1; d_mode = 1;
      repeat (800) step();
      drain();

      // Reset while the fetch is in ISSUE.
      @(negedge clk_in);
      i_req = 1'b1; i_addr = 32'h0040_0010;
      model();
      @(negedge clk_in);        // ISSUE cycle
      #2;
      reset_n = 1'b0;
      i_req   = 1'b0;
      ack_q.delete(); mem_q.delete();
      starve  = 0;
      @(negedge clk_in);
      check_idle_outputs("mid_reset");
      reset_n = 1'b1;
      free_at = cyc;
      @(negedge clk_in);
      i_req = 1'b1; i_addr = 32'h0040_0010;
      model();
      drain();

      // More random traffic after the reset.
      i_mode = 1; d_mode = 2;
      repeat (300) step();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
